m_seq_code_gen: RTL

//  Upstream stage of the 2PSK/2ASK/2FSK modulators. Generates the serial binary m-sequence
//  (maximal-length LFSR PN code) driving m_ser_code_in of the modulator select stage.
//  - Bit period is programmable in clk cycles.
//  - Provides bit and frame strobes for scope triggering and for the downstream modulator.

---
 rtl/mod_pkg.sv | 45 ++++
 rtl/lfsr_core.sv | 43 ++++
 rtl/m_seq_code_gen.sv | 78 +++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared constants for the 2PSK/2ASK/2FSK modulator chain and default
// PN-generator settings for each supported LFSR degree.
package mod_pkg;

  localparam int CODE_W     = 1;
  localparam int DDS_DATA_W = 10;
  localparam int DIV_W      = 16;

  localparam int             LEN_4   = 4;
  localparam logic [3:0]     TAPS_4  = 4'b1100;              // x^4+x^3+1
  localparam logic [3:0]     SEED_4  = 4'b0001;
  localparam int             LEN_7   = 7;
  localparam logic [6:0]     TAPS_7  = 7'b1100000;           // x^7+x^6+1
  localparam logic [6:0]     SEED_7  = 7'b0000001;
  localparam int             LEN_9   = 9;
  localparam logic [8:0]     TAPS_9  = 9'b100010000;         // x^9+x^5+1
  localparam logic [8:0]     SEED_9  = 9'b000000001;
  localparam int             LEN_15  = 15;
  localparam logic [14:0]    TAPS_15 = 15'h6000;             // x^15+x^14+1
  localparam logic [14:0]    SEED_15 = 15'h0001;

  typedef enum logic [1:0] {DEG_4, DEG_7, DEG_9, DEG_15} lfsr_deg_e;

  typedef struct packed {
    logic [4:0]  len;
    logic [14:0] taps;
    logic [14:0] seed;
  } lfsr_cfg_t;

  function automatic lfsr_cfg_t lfsr_cfg(lfsr_deg_e deg);
    lfsr_cfg_t c;
    case (deg)
      DEG_4:   c = '{len: 5'd4,  taps: 15'(TAPS_4), seed: 15'(SEED_4)};
      DEG_9:   c = '{len: 5'd9,  taps: 15'(TAPS_9), seed: 15'(SEED_9)};
      DEG_15:  c = '{len: 5'd15, taps: TAPS_15,     seed: SEED_15};
      default: c = '{len: 5'd7,  taps: 15'(TAPS_7), seed: 15'(SEED_7)};
    endcase
    return c;
  endfunction

  function automatic int seq_period(int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci shift-left LFSR state with seed load and all-zero lock-up guard.
// nxt is the value the register takes on load or shift.
module lfsr_core #(
  parameter int                  LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] TAPS     = 7'b1100000,
  parameter logic [LFSR_LEN-1:0] SEED     = 7'b0000001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic [LFSR_LEN-1:0] nxt,
  output logic                zero_err
);

  logic [LFSR_LEN-1:0] lfsr;
  logic                fb;

  // Load beats shift; a zero seed or a zero state both fall back to SEED.
  always_comb begin
    fb       = ^(lfsr & TAPS);
    nxt      = {lfsr[LFSR_LEN-2:0], fb};
    zero_err = 1'b0;
    if (load) begin
      if (seed_in == '0) begin
        nxt      = SEED;
        zero_err = 1'b1;
      end else begin
        nxt = seed_in;
      end
    end else if (lfsr == '0) begin
      nxt      = SEED;
      zero_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                lfsr <= SEED;
    else if (load || shift) lfsr <= nxt;
  end

endmodule

// File: rtl/m_seq_code_gen.sv
// Serial m-sequence PN code source with programmable bit period and
// bit / frame strobes for the downstream modulator select stage.
module m_seq_code_gen #(
  parameter int                  LFSR_LEN = mod_pkg::LEN_7,
  parameter logic [LFSR_LEN-1:0] TAPS     = mod_pkg::TAPS_7,
  parameter logic [LFSR_LEN-1:0] SEED     = mod_pkg::SEED_7,
  parameter int                  DIV_W    = mod_pkg::DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_W-1:0]    bit_div,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic                m_ser_code_out,
  output logic                bit_strobe,
  output logic                frame_start,
  output logic                seed_err
);
  import mod_pkg::*;

  localparam logic [LFSR_LEN-1:0] BIT_LAST = LFSR_LEN'(seq_period(LFSR_LEN) - 1);

  logic [DIV_W-1:0]    div_cnt, div_lat;
  logic [LFSR_LEN-1:0] bit_cnt, nxt;
  logic                zero_err, shift;

  // div_lat is only refreshed at a bit boundary so a bit_div change never truncates a bit.
  assign shift = en && !seed_load && (div_cnt == div_lat);

  lfsr_core #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .SEED     (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .load     (seed_load),
    .seed_in  (seed_in),
    .nxt      (nxt),
    .zero_err (zero_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt        <= '0;
      bit_cnt        <= '0;
      div_lat        <= bit_div;
      m_ser_code_out <= SEED[LFSR_LEN-1];
      bit_strobe     <= 1'b0;
      frame_start    <= 1'b0;
      seed_err       <= 1'b0;
    end else if (seed_load) begin
      div_cnt        <= '0;
      bit_cnt        <= '0;
      div_lat        <= bit_div;
      m_ser_code_out <= nxt[LFSR_LEN-1];
      bit_strobe     <= 1'b1;
      frame_start    <= 1'b1;
      seed_err       <= zero_err;
    end else if (shift) begin
      div_cnt        <= '0;
      div_lat        <= bit_div;
      bit_cnt        <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + LFSR_LEN'(1);
      m_ser_code_out <= nxt[LFSR_LEN-1];
      bit_strobe     <= 1'b1;
      frame_start    <= (bit_cnt == BIT_LAST);
      seed_err       <= zero_err;
    end else begin
      if (en) div_cnt <= div_cnt + DIV_W'(1);
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      seed_err    <= 1'b0;
    end
  end

endmodule
